// File: rtl/fine_delay_interp.sv
`default_nettype none
// ============================================================================
//  Module   : fine_delay_interp
//  Brief    : Per-channel fine-delay stage. Applies a per-sample fractional
//             delay to coarse-delayed samples by 2-tap linear interpolation,
//             with fraction codes taken from a host-loaded LUT. The output
//             carries a gain of 2^FRAC_WD, which the downstream summer removes.
//  Options  : FINE_APOD_EN - adds a third stage that scales the interpolated
//             sample by a signed Q1.(APO_WD-1) apodisation weight.
//  Revision : 1.0 - initial release
// ============================================================================
module fine_delay_interp #(
    parameter int INPUT_WD  = 14,
    parameter int FRAC_WD   = 3,
    parameter int ADDR_WD   = 12,
    parameter int FD_OUT_WD = 18,   // must equal INPUT_WD + FRAC_WD + 1
    parameter int APO_WD    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        tx_en,
    input  logic [ADDR_WD-1:0]          lut_addr,
    input  logic                        lut_wr_en,
    input  logic [FRAC_WD-1:0]          lut_din,
    input  logic signed [INPUT_WD-1:0]  fine_din,
    input  logic                        fine_din_valid,
    input  logic signed [APO_WD-1:0]    apo_din,
    output logic signed [FD_OUT_WD-1:0] fine_dout,
    output logic                        fine_dout_valid
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FILL = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    localparam logic [ADDR_WD-1:0] c_IDX_MAX  = {ADDR_WD{1'b1}};
    localparam logic [FRAC_WD:0]   c_FRAC_ONE = {1'b1, {FRAC_WD{1'b0}}};

    logic [FRAC_WD-1:0]          r_mem [2**ADDR_WD];
    logic [1:0]                  r_state;
    logic                        r_start_d;
    logic [ADDR_WD-1:0]          r_idx;
    logic signed [INPUT_WD-1:0]  r_x_prev;

    logic                        r_s1_valid;
    logic signed [INPUT_WD-1:0]  r_s1_xprev;
    logic signed [INPUT_WD-1:0]  r_s1_xcur;
    logic [FRAC_WD-1:0]          r_s1_f;

    logic                        r_dout_valid;
    logic signed [FD_OUT_WD-1:0] r_dout;

    logic                        w_start_rise;
    logic                        w_acc;
    logic                        w_run_acc;
    logic [FRAC_WD:0]            w_wt_prev;
    logic signed [FD_OUT_WD-1:0] w_xprev_ext;
    logic signed [FD_OUT_WD-1:0] w_xcur_ext;
    logic signed [FD_OUT_WD-1:0] w_wprev_ext;
    logic signed [FD_OUT_WD-1:0] w_wcur_ext;
    logic signed [FD_OUT_WD-1:0] w_interp;

    assign w_start_rise = start & ~r_start_d;
    assign w_acc        = fine_din_valid & start & ~tx_en;
    // A start rising edge takes priority: that cycle re-enters FILL instead.
    assign w_run_acc    = w_acc & (r_state == c_ST_RUN) & ~w_start_rise;

    // Weights are unsigned FRAC_WD+1 bits; zero-extend them and sign-extend
    // the taps so the whole multiply-add runs in signed FD_OUT_WD, which
    // is wide enough that the sum never overflows.
    assign w_wt_prev   = c_FRAC_ONE - {1'b0, r_s1_f};
    assign w_xprev_ext = {{(FD_OUT_WD-INPUT_WD){r_s1_xprev[INPUT_WD-1]}}, r_s1_xprev};
    assign w_xcur_ext  = {{(FD_OUT_WD-INPUT_WD){r_s1_xcur[INPUT_WD-1]}}, r_s1_xcur};
    assign w_wprev_ext = {{(FD_OUT_WD-FRAC_WD-1){1'b0}}, w_wt_prev};
    assign w_wcur_ext  = {{(FD_OUT_WD-FRAC_WD){1'b0}}, r_s1_f};
    assign w_interp    = (w_xprev_ext * w_wprev_ext) + (w_xcur_ext * w_wcur_ext);

    // Host write port of the fraction LUT; contents survive reset.
    always_ff @(posedge clk) begin
        if (lut_wr_en) begin
            r_mem[lut_addr] <= lut_din;
        end
    end

    // Delayed copy of start for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start;
        end
    end

    // Frame control: state, fraction index and the previous-sample tap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_x_prev <= '0;
        end else if (!start) begin
            r_state <= c_ST_IDLE;
        end else if (w_start_rise) begin
            r_state  <= c_ST_FILL;
            r_idx    <= '0;
            r_x_prev <= '0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_acc) begin
                        r_x_prev <= fine_din;
                        r_state  <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_acc) begin
                        r_x_prev <= fine_din;
                        // Hold the last fraction once the LUT end is reached.
                        if (r_idx != c_IDX_MAX) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1: capture both taps and the fraction code for this accept.
    // The LUT read sees pre-write data when the host writes the same address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_xprev <= '0;
            r_s1_xcur  <= '0;
            r_s1_f     <= '0;
        end else begin
            r_s1_valid <= w_run_acc;
            if (w_run_acc) begin
                r_s1_xprev <= r_x_prev;
                r_s1_xcur  <= fine_din;
                r_s1_f     <= r_mem[r_idx];
            end
        end
    end

`ifdef FINE_APOD_EN
    localparam logic signed [APO_WD-1:0] c_APO_UNITY = {1'b0, {(APO_WD-1){1'b1}}};

    logic                               r_s2_valid;
    logic signed [FD_OUT_WD-1:0]        r_s2;
    logic signed [FD_OUT_WD+APO_WD-1:0] w_apo_prod;
    logic                               w_unused_apo_bits;

    // Slicing above bit APO_WD-2 is the arithmetic shift plus truncation.
    assign w_apo_prod = {{APO_WD{r_s2[FD_OUT_WD-1]}}, r_s2}
                      * {{FD_OUT_WD{apo_din[APO_WD-1]}}, apo_din};
    assign w_unused_apo_bits = ^{w_apo_prod[FD_OUT_WD+APO_WD-1], w_apo_prod[APO_WD-2:0]};

    // Stage 2: register the interpolated sample; start low flushes it.
    always_ff @(posedge clk) begin
        if (!rst_n || !start) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_interp;
            end
        end
    end

    // Stage 3: apodisation; the largest positive weight passes interp exactly.
    always_ff @(posedge clk) begin
        if (!rst_n || !start) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
        end else begin
            r_dout_valid <= r_s2_valid;
            if (r_s2_valid) begin
                if (apo_din == c_APO_UNITY) begin
                    r_dout <= r_s2;
                end else begin
                    r_dout <= w_apo_prod[APO_WD-1 +: FD_OUT_WD];
                end
            end
        end
    end
`else
    logic w_unused_apo;

    assign w_unused_apo = ^apo_din;

    // Stage 2: register the multiply-add; output holds between pulses and
    // is forced to zero as soon as the frame ends.
    always_ff @(posedge clk) begin
        if (!rst_n || !start) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
        end else begin
            r_dout_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dout <= w_interp;
            end
        end
    end
`endif

    assign fine_dout       = r_dout;
    assign fine_dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_fine_delay_interp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fine_delay_interp
//  Brief    : Directed self-checking bench for fine_delay_interp (default
//             build). A second instance with ADDR_WD=2 exercises the
//             fraction-index saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fine_delay_interp;

    localparam int INPUT_WD  = 14;
    localparam int FRAC_WD   = 3;
    localparam int ADDR_WD   = 12;
    localparam int FD_OUT_WD = 18;
    localparam int APO_WD    = 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start;
    logic                        tx_en;
    logic [ADDR_WD-1:0]          lut_addr;
    logic                        lut_wr_en;
    logic [FRAC_WD-1:0]          lut_din;
    logic signed [INPUT_WD-1:0]  fine_din;
    logic                        fine_din_valid;
    logic signed [APO_WD-1:0]    apo_din;
    logic signed [FD_OUT_WD-1:0] fine_dout;
    logic                        fine_dout_valid;
    logic signed [FD_OUT_WD-1:0] sat_dout;
    logic                        sat_dout_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fine_delay_interp #(
        .INPUT_WD (INPUT_WD), .FRAC_WD (FRAC_WD), .ADDR_WD (ADDR_WD),
        .FD_OUT_WD(FD_OUT_WD), .APO_WD (APO_WD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .tx_en          (tx_en),
        .lut_addr       (lut_addr),
        .lut_wr_en      (lut_wr_en),
        .lut_din        (lut_din),
        .fine_din       (fine_din),
        .fine_din_valid (fine_din_valid),
        .apo_din        (apo_din),
        .fine_dout      (fine_dout),
        .fine_dout_valid(fine_dout_valid)
    );

    fine_delay_interp #(
        .INPUT_WD (INPUT_WD), .FRAC_WD (FRAC_WD), .ADDR_WD (2),
        .FD_OUT_WD(FD_OUT_WD), .APO_WD (APO_WD)
    ) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .tx_en          (tx_en),
        .lut_addr       (lut_addr[1:0]),
        .lut_wr_en      (lut_wr_en),
        .lut_din        (lut_din),
        .fine_din       (fine_din),
        .fine_din_valid (fine_din_valid),
        .apo_din        (apo_din),
        .fine_dout      (sat_dout),
        .fine_dout_valid(sat_dout_valid)
    );

    // One clock of stimulus; outputs are observed 1 ns after the edge.
    task automatic step(input logic s, input logic v, input logic tx, input int x);
        start          = s;
        fine_din_valid = v;
        tx_en          = tx;
        fine_din       = INPUT_WD'(x);
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input int a, input int d);
        lut_wr_en = 1'b1;
        lut_addr  = ADDR_WD'(a);
        lut_din   = FRAC_WD'(d);
        @(posedge clk);
        #1;
        lut_wr_en = 1'b0;
    endtask

    // Drop start for a cycle, then raise it with no sample (enters FILL).
    task automatic start_frame();
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (fine_dout_valid !== 1'b0 || fine_dout !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b dout=%0d, want valid=0 dout=0",
                     fine_dout_valid, fine_dout);
        end
        checks++;
        if (sat_dout_valid !== 1'b0 || sat_dout !== '0) begin
            failures++;
            $display("FAIL reset_state_sat: got valid=%b dout=%0d, want valid=0 dout=0",
                     sat_dout_valid, sat_dout);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int xs[7] = '{100, 200, 300, 400, 500, 0, 0};
        bit vs[7] = '{1, 1, 1, 1, 1, 0, 0};
        bit ev[7] = '{0, 0, 1, 1, 1, 1, 0};
        int ed[7] = '{0, 0, 800, 2000, 3100, 3400, 3400};
        logic signed [FD_OUT_WD-1:0] e;
        start_frame();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vs[i], 1'b0, xs[i]);
            e = FD_OUT_WD'(ed[i]);
            checks++;
            if (fine_dout_valid !== ev[i] || fine_dout !== e) begin
                failures++;
                $display("FAIL back_to_back cyc%0d: got valid=%b dout=%0d, want valid=%b dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], e);
            end
        end
    endtask

    task automatic test_gapped();
        int xs[11] = '{100, -1234, 200, -1234, 300, -1234, 400, -1234, 500, -1234, -1234};
        bit vs[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
        bit ev[11] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int ed[11] = '{0, 0, 0, 800, 800, 2000, 2000, 3100, 3100, 3400, 3400};
        logic signed [FD_OUT_WD-1:0] e;
        start_frame();
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vs[i], 1'b0, xs[i]);
            e = FD_OUT_WD'(ed[i]);
            checks++;
            if (fine_dout_valid !== ev[i] || fine_dout !== e) begin
                failures++;
                $display("FAIL gapped cyc%0d: got valid=%b dout=%0d, want valid=%b dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], e);
            end
        end
    endtask

    // 300 is dropped: 400 pairs with 200 and uses the next unused fraction.
    task automatic test_tx_drop();
        int xs[7] = '{100, 200, 300, 400, 500, 0, 0};
        bit vs[7] = '{1, 1, 1, 1, 1, 0, 0};
        bit ts[7] = '{0, 0, 1, 0, 0, 0, 0};
        bit ev[7] = '{0, 0, 1, 0, 1, 1, 0};
        int ed[7] = '{0, 0, 800, 800, 2400, 3900, 3900};
        logic signed [FD_OUT_WD-1:0] e;
        start_frame();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vs[i], ts[i], xs[i]);
            e = FD_OUT_WD'(ed[i]);
            checks++;
            if (fine_dout_valid !== ev[i] || fine_dout !== e) begin
                failures++;
                $display("FAIL tx_drop cyc%0d: got valid=%b dout=%0d, want valid=%b dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], e);
            end
        end
    endtask

    task automatic test_stop_restart();
        bit ss[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        bit vs[10] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
        int xs[10] = '{100, 200, 300, 400, 0, 0, 500, 600, 0, 0};
        bit ev[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        int ed[10] = '{0, 0, 800, 0, 0, 0, 0, 0, 4000, 4000};
        logic signed [FD_OUT_WD-1:0] e;
        start_frame();
        for (int i = 0; i < 10; i++) begin
            step(ss[i], vs[i], 1'b0, xs[i]);
            e = FD_OUT_WD'(ed[i]);
            checks++;
            if (fine_dout_valid !== ev[i] || fine_dout !== e) begin
                failures++;
                $display("FAIL stop_restart cyc%0d: got valid=%b dout=%0d, want valid=%b dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], e);
            end
        end
    endtask

    // Host rewrites LUT[0] in the very cycle it is read: the old code 0 is used.
    task automatic test_lut_collision();
        start_frame();
        step(1'b1, 1'b1, 1'b0, 100);
        lut_wr_en = 1'b1;
        lut_addr  = '0;
        lut_din   = FRAC_WD'(5);
        step(1'b1, 1'b1, 1'b0, 200);
        lut_wr_en = 1'b0;
        step(1'b1, 1'b1, 1'b0, 300);
        checks++;
        if (fine_dout_valid !== 1'b1 || fine_dout !== 18'sd800) begin
            failures++;
            $display("FAIL lut_collision_old: got valid=%b dout=%0d, want valid=1 dout=800",
                     fine_dout_valid, fine_dout);
        end
        step(1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (fine_dout_valid !== 1'b1 || fine_dout !== 18'sd2000) begin
            failures++;
            $display("FAIL lut_collision_next: got valid=%b dout=%0d, want valid=1 dout=2000",
                     fine_dout_valid, fine_dout);
        end
        // The new code 5 must be visible in the next frame: 3*100 + 5*200.
        start_frame();
        step(1'b1, 1'b1, 1'b0, 100);
        step(1'b1, 1'b1, 1'b0, 200);
        step(1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (fine_dout_valid !== 1'b1 || fine_dout !== 18'sd1300) begin
            failures++;
            $display("FAIL lut_collision_new: got valid=%b dout=%0d, want valid=1 dout=1300",
                     fine_dout_valid, fine_dout);
        end
        step(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_signed();
        int xs[6] = '{-100, 50, -8192, 8191, 0, 0};
        bit vs[6] = '{1, 1, 1, 1, 0, 0};
        bit ev[6] = '{0, 0, 1, 1, 1, 0};
        int ed[6] = '{0, 0, -350, -40810, -49153, -49153};
        logic signed [FD_OUT_WD-1:0] e;
        lut_write(0, 3);
        lut_write(1, 5);
        lut_write(2, 1);
        start_frame();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vs[i], 1'b0, xs[i]);
            e = FD_OUT_WD'(ed[i]);
            checks++;
            if (fine_dout_valid !== ev[i] || fine_dout !== e) begin
                failures++;
                $display("FAIL signed cyc%0d: got valid=%b dout=%0d, want valid=%b dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], e);
            end
        end
    endtask

    // 4-entry LUT: the fifth output must reuse f=3 (wrap would give 410).
    task automatic test_saturation();
        int xs[8] = '{10, 20, 30, 40, 50, 60, 0, 0};
        bit vs[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit ev[8] = '{0, 0, 1, 1, 1, 1, 1, 0};
        int ed[8] = '{0, 0, 90, 170, 250, 350, 430, 430};
        logic signed [FD_OUT_WD-1:0] e;
        lut_write(0, 1);
        lut_write(1, 1);
        lut_write(2, 1);
        lut_write(3, 3);
        start_frame();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vs[i], 1'b0, xs[i]);
            e = FD_OUT_WD'(ed[i]);
            checks++;
            if (sat_dout_valid !== ev[i] || sat_dout !== e) begin
                failures++;
                $display("FAIL saturation cyc%0d: got valid=%b dout=%0d, want valid=%b dout=%0d",
                         i, sat_dout_valid, sat_dout, ev[i], e);
            end
        end
    endtask

    task automatic test_reset_midstream();
        start_frame();
        step(1'b1, 1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 1'b0, 20);
        step(1'b1, 1'b1, 1'b0, 30);
        checks++;
        if (fine_dout_valid !== 1'b1 || fine_dout !== 18'sd90) begin
            failures++;
            $display("FAIL midreset_pre: got valid=%b dout=%0d, want valid=1 dout=90",
                     fine_dout_valid, fine_dout);
        end
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0, 40);
        checks++;
        if (fine_dout_valid !== 1'b0 || fine_dout !== '0) begin
            failures++;
            $display("FAIL midreset_out: got valid=%b dout=%0d, want valid=0 dout=0",
                     fine_dout_valid, fine_dout);
        end
        step(1'b1, 1'b1, 1'b0, 50);
        checks++;
        if (fine_dout_valid !== 1'b0 || fine_dout !== '0) begin
            failures++;
            $display("FAIL midreset_hold: got valid=%b dout=%0d, want valid=0 dout=0",
                     fine_dout_valid, fine_dout);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        tx_en          = 1'b0;
        lut_addr       = '0;
        lut_wr_en      = 1'b0;
        lut_din        = '0;
        fine_din       = '0;
        fine_din_valid = 1'b0;
        apo_din        = 16'sd16384;

        test_reset();
        lut_write(0, 0);
        lut_write(1, 4);
        lut_write(2, 7);
        lut_write(3, 2);
        test_back_to_back();
        test_gapped();
        test_tx_drop();
        test_stop_restart();
        test_lut_collision();
        lut_write(0, 0);
        test_signed();
        test_saturation();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
